synth_bus_arbiter: RTL and testbench
====================================

// Module: synth_bus_arbiter
// PURPOSE
//  Arbitrates the synth parameter bus between the CPU slave port and the MIDI decoder sysex/param port.
//  Owns a PARTS-deep multi-timbral MIDI-channel register bank in the common page.
//  Drives one-hot page selects, address, strobes and write data into synth_engine/synth_controller.
//  Returns read data with an explicit valid handshake.
// PARAMETERS
//  ADDR_W    7   offset width within a page
//  DATA_W    8   parameter data width
//  PARTS     4   multi-timbral parts, one 4-bit MIDI channel register each
//  PART_W    utils::clogb2(PARTS)   part index width
//  COM_BASE  2   common-page offset of part 0 channel register; part p at COM_BASE+p
//  RD_LAT    1   bus_rdata latency in data_clk cycles after bus_read strobe (1..3)
// PORTS
//  data_clk       in   1           sole clock, all logic on posedge
//  reset          in   1           asynchronous, active-high
//  cpu_write      in   1           CPU write request, held until cpu_waitrequest low
//  cpu_read       in   1           CPU read request, held until cpu_waitrequest low
//  cpu_addr       in   3+ADDR_W    [ADDR_W+2:ADDR_W]=page, [ADDR_W-1:0]=offset
//  cpu_wdata      in   32          write data, [DATA_W-1:0] used
//  cpu_rdata      out  32          read data, zero-extended, valid with cpu_rdvalid
//  cpu_waitrequest out 1           = (cpu_read|cpu_write) & ~cpu_done (combinational)
//  cpu_rdvalid    out  1           one-cycle pulse, read data valid
//  dec_valid      in   1           decoder request, held until dec_ready
//  dec_write      in   1           1=write, 0=read (sysex patch dump)
//  dec_page       in   3           page number
//  dec_addr       in   ADDR_W      offset
//  dec_wdata      in   DATA_W      write data
//  dec_ready      out  1           one-cycle pulse, request completed
//  dec_rdata      out  DATA_W      read data, valid with dec_ready on reads
//  bus_sel        out  5           one-hot {com,m2,m1,osc,env}
//  bus_adr        out  ADDR_W      bus offset
//  bus_write      out  1           write strobe, one cycle
//  bus_read       out  1           read strobe, one cycle
//  bus_wdata      out  DATA_W      write data
//  bus_rdata      in   DATA_W      engine read data
//  syx_out        out  1           high while the owning transaction belongs to the decoder
//  midi_ch        out  4*PARTS     part p channel at [4p+3:4p]
// BEHAVIOUR
//  Pages 0..4 = env, osc, m1, m2, com; pages 5..7 are invalid.
//  FSM IDLE -> ISSUE -> (write) DONE | (read) RDWAIT -> DONE -> IDLE.
//  IDLE: sample requests and grant one master; latch page/adr/data/rw/owner.
//  ISSUE: drive bus_sel, bus_adr, bus_wdata and exactly one strobe for one cycle; syx_out = owner==dec.
//  RDWAIT: count RD_LAT cycles, then capture bus_rdata.
//  DONE: pulse cpu_done + cpu_rdvalid (read) or dec_ready; return to IDLE.
//  Latency, request in cycle 0: strobe in cycle 1; write completes in cycle 2; read completes in cycle 2+RD_LAT.
//  Back-to-back: a new grant is possible in the cycle after DONE.
//  Arbitration: the decoder wins on simultaneous requests (fixed priority).
//  Common page COM_BASE..COM_BASE+PARTS-1:
//    write updates midi_ch[p] <= wdata[3:0] in the ISSUE cycle and is also forwarded to the bus;
//    read returns {0,midi_ch[p]}, bus_rdata ignored.
//  Invalid page: no bus_sel bit, no strobe; write dropped; read returns 0; completes with normal latency (no hang).
//  Both cpu_read and cpu_write high: treated as write.
//  Requests dropped mid-transaction are not cancelled; completion pulses anyway.
//  Reset (any cycle, mid-transaction included): FSM->IDLE, transaction aborted, no completion pulse.
//    All registered outputs 0; midi_ch[p] = p mod 16.
// CONFIGURATION
//  SYNTH_BUS_RR_ARB_EN defined:
//    round-robin, last-served master loses on simultaneous requests;
//    winner pointer resets to decoder-preferred.
//  Undefined: fixed decoder priority as above.
// STRUCTURE
//  synth_bus_pkg:
//    typedef enum page_t {PG_ENV,PG_OSC,PG_M1,PG_M2,PG_COM};
//    typedef enum state_t {IDLE,ISSUE,RDWAIT,DONE};
//    localparam NUM_PAGES=5, CH_W=4.
//  Sub-module synth_com_regs: PARTS channel bank, write port, read mux, reset values.
// TESTING
//  1. Reset, no requests -> midi_ch=={4'd3,4'd2,4'd1,4'd0}; all strobes 0; cpu_waitrequest 0.
//  2. CPU write page1 adr 0x10 data 0x5A -> cycle1 bus_sel=5'b00010, bus_adr=0x10, bus_write=1, bus_wdata=0x5A; waitrequest low in cycle 2.
//  3. CPU read page4 adr COM_BASE+2 after dec write 0x09 there -> cpu_rdata=0x9, cpu_rdvalid at cycle 2+RD_LAT; bus_write seen once with syx_out=1.
//  4. Same-cycle CPU write + dec read page0 adr 3 -> dec served first (syx_out=1), CPU strobe follows; with SYNTH_BUS_RR_ARB_EN and repeated contention, grants alternate.
//  5. CPU read page 6 -> no strobe, cpu_rdata=0, cpu_rdvalid at cycle 2+RD_LAT.
//  6. Reset asserted during RDWAIT -> no cpu_rdvalid; FSM IDLE; midi_ch back to defaults; next request served normally.

Source files
------------

// File: rtl/synth_bus_pkg.sv
// Shared types, constants and helpers for the synth parameter bus arbiter.
package synth_bus_pkg;

  localparam int NUM_PAGES = 5;
  localparam int CH_W      = 4;

  typedef enum logic [2:0] {
    PG_ENV = 3'd0,
    PG_OSC = 3'd1,
    PG_M1  = 3'd2,
    PG_M2  = 3'd3,
    PG_COM = 3'd4
  } page_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    DONE
  } state_t;

  // Index width for n items, never less than one bit.
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Pages 5..7 decode to no select bit at all.
  function automatic logic [NUM_PAGES-1:0] page_onehot(input logic [2:0] pg);
    logic [NUM_PAGES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (pg == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic page_valid(input logic [2:0] pg);
    return pg < 3'(NUM_PAGES);
  endfunction

endpackage

// File: rtl/synth_com_regs.sv
// Multi-timbral MIDI channel register bank living in the common page.
// Part p resets to channel p mod 16.
module synth_com_regs
  import synth_bus_pkg::*;
#(
  parameter int PARTS  = 4,
  parameter int PART_W = clogb2(PARTS)
) (
  input  logic                  data_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [PART_W-1:0]     wr_part,
  input  logic [CH_W-1:0]       wr_data,
  input  logic [PART_W-1:0]     rd_part,
  output logic [CH_W-1:0]       rd_data,
  output logic [CH_W*PARTS-1:0] midi_ch
);

  logic [CH_W-1:0] ch_q [PARTS];

  // Channel bank: reset defaults, single write port.
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < PARTS; p++) ch_q[p] <= CH_W'(p % 16);
    end else if (wr_en && (int'(wr_part) < PARTS)) begin
      ch_q[wr_part] <= wr_data;
    end
  end

  // Read mux, zero for a part index beyond the bank.
  always_comb begin
    rd_data = '0;
    if (int'(rd_part) < PARTS) rd_data = ch_q[rd_part];
  end

  for (genvar p = 0; p < PARTS; p++) begin : g_ch
    assign midi_ch[CH_W*p +: CH_W] = ch_q[p];
  end

endmodule

// File: rtl/synth_bus_arbiter.sv
// Arbitrates the synth parameter bus between the CPU slave port and the
// MIDI decoder port, and owns the common-page MIDI channel bank.
// Optional build macro SYNTH_BUS_RR_ARB_EN: round-robin arbitration
// (last-served master loses on contention). Default: decoder has priority.
module synth_bus_arbiter
  import synth_bus_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int PARTS    = 4,
  parameter int PART_W   = clogb2(PARTS),
  parameter int COM_BASE = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                  data_clk,
  input  logic                  reset,
  input  logic                  cpu_write,
  input  logic                  cpu_read,
  input  logic [ADDR_W+2:0]     cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_waitrequest,
  output logic                  cpu_rdvalid,
  input  logic                  dec_valid,
  input  logic                  dec_write,
  input  logic [2:0]            dec_page,
  input  logic [ADDR_W-1:0]     dec_addr,
  input  logic [DATA_W-1:0]     dec_wdata,
  output logic                  dec_ready,
  output logic [DATA_W-1:0]     dec_rdata,
  output logic [NUM_PAGES-1:0]  bus_sel,
  output logic [ADDR_W-1:0]     bus_adr,
  output logic                  bus_write,
  output logic                  bus_read,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  syx_out,
  output logic [CH_W*PARTS-1:0] midi_ch
);

  localparam logic [ADDR_W-1:0] COM_LO = ADDR_W'(COM_BASE);
  localparam logic [ADDR_W-1:0] COM_HI = ADDR_W'(COM_BASE + PARTS);

  state_t              state_q;
  logic                cpu_done;
  logic                own_dec_q;
  logic                wr_q;
  logic [2:0]          page_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          cnt_q;

  logic                cpu_req;
  logic                pref_dec;
  logic                grant_dec;
  logic                grant_cpu;
  logic [2:0]          req_page;
  logic [ADDR_W-1:0]   req_adr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_wr;

  logic                com_hit;
  logic [PART_W-1:0]   com_part;
  logic [CH_W-1:0]     com_rd;
  logic                com_wr_en;
  logic [DATA_W-1:0]   rd_val;
  logic                unused_cpu_wdata;

  assign unused_cpu_wdata = ^cpu_wdata[31:DATA_W];

  // A CPU request with both read and write high is a write.
  assign cpu_req         = cpu_read | cpu_write;
  assign cpu_waitrequest = cpu_req & ~cpu_done;

  assign grant_dec = dec_valid & (~cpu_req | pref_dec);
  assign grant_cpu = cpu_req & ~grant_dec;

`ifdef SYNTH_BUS_RR_ARB_EN
  // Round-robin pointer: the master just granted loses the next tie.
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      pref_dec <= 1'b1;
    end else if (state_q == IDLE && (grant_dec || grant_cpu)) begin
      pref_dec <= ~grant_dec;
    end
  end
`else
  assign pref_dec = 1'b1;
`endif

  // Request mux feeding the transaction latch.
  always_comb begin
    req_page  = cpu_addr[ADDR_W+2:ADDR_W];
    req_adr   = cpu_addr[ADDR_W-1:0];
    req_wdata = cpu_wdata[DATA_W-1:0];
    req_wr    = cpu_write;
    if (grant_dec) begin
      req_page  = dec_page;
      req_adr   = dec_addr;
      req_wdata = dec_wdata;
      req_wr    = dec_write;
    end
  end

  assign com_hit   = (page_q == PG_COM) && (adr_q >= COM_LO) && (adr_q < COM_HI);
  assign com_part  = PART_W'(adr_q - COM_LO);
  assign com_wr_en = (state_q == ISSUE) && wr_q && com_hit;

  // Read return: invalid page reads zero, channel registers shadow the bus.
  always_comb begin
    rd_val = bus_rdata;
    if (!page_valid(page_q)) rd_val = '0;
    else if (com_hit)        rd_val = DATA_W'(com_rd);
  end

  synth_com_regs #(
    .PARTS  (PARTS),
    .PART_W (PART_W)
  ) u_com_regs (
    .data_clk (data_clk),
    .reset    (reset),
    .wr_en    (com_wr_en),
    .wr_part  (com_part),
    .wr_data  (wdata_q[CH_W-1:0]),
    .rd_part  (com_part),
    .rd_data  (com_rd),
    .midi_ch  (midi_ch)
  );

  // Transaction FSM with registered bus strobes and completion pulses.
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_done    <= 1'b0;
      own_dec_q   <= 1'b0;
      wr_q        <= 1'b0;
      page_q      <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata   <= '0;
      cpu_rdvalid <= 1'b0;
      dec_ready   <= 1'b0;
      dec_rdata   <= '0;
      bus_sel     <= '0;
      bus_adr     <= '0;
      bus_write   <= 1'b0;
      bus_read    <= 1'b0;
      bus_wdata   <= '0;
      syx_out     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_dec || grant_cpu) begin
            state_q   <= ISSUE;
            own_dec_q <= grant_dec;
            syx_out   <= grant_dec;
            page_q    <= req_page;
            adr_q     <= req_adr;
            wdata_q   <= req_wdata;
            wr_q      <= req_wr;
            bus_sel   <= page_onehot(req_page);
            bus_adr   <= req_adr;
            bus_wdata <= req_wdata;
            bus_write <= req_wr & page_valid(req_page);
            bus_read  <= ~req_wr & page_valid(req_page);
          end
        end
        ISSUE: begin
          bus_sel   <= '0;
          bus_write <= 1'b0;
          bus_read  <= 1'b0;
          if (wr_q) begin
            state_q   <= DONE;
            cpu_done  <= ~own_dec_q;
            dec_ready <= own_dec_q;
          end else begin
            state_q <= RDWAIT;
            cnt_q   <= 2'(RD_LAT - 1);
          end
        end
        RDWAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= DONE;
            if (own_dec_q) begin
              dec_rdata <= rd_val;
              dec_ready <= 1'b1;
            end else begin
              cpu_rdata   <= 32'(rd_val);
              cpu_done    <= 1'b1;
              cpu_rdvalid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cpu_done    <= 1'b0;
          cpu_rdvalid <= 1'b0;
          dec_ready   <= 1'b0;
          syx_out     <= 1'b0;
          own_dec_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_bus_arbiter.sv
// Directed bench for synth_bus_arbiter (default parameters, RD_LAT = 1).
module tb_synth_bus_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int PARTS  = 4;

`ifdef SYNTH_BUS_RR_ARB_EN
  localparam logic [2:0] EXP_PAT = 3'b101;
`else
  localparam logic [2:0] EXP_PAT = 3'b111;
`endif

  logic                 data_clk = 1'b0;
  logic                 reset;
  logic                 cpu_write, cpu_read;
  logic [ADDR_W+2:0]    cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_waitrequest, cpu_rdvalid;
  logic                 dec_valid, dec_write;
  logic [2:0]           dec_page;
  logic [ADDR_W-1:0]    dec_addr;
  logic [DATA_W-1:0]    dec_wdata;
  logic                 dec_ready;
  logic [DATA_W-1:0]    dec_rdata;
  logic [4:0]           bus_sel;
  logic [ADDR_W-1:0]    bus_adr;
  logic                 bus_write, bus_read;
  logic [DATA_W-1:0]    bus_wdata;
  logic [DATA_W-1:0]    bus_rdata;
  logic                 syx_out;
  logic [4*PARTS-1:0]   midi_ch;

  int errors = 0;
  int checks = 0;

  synth_bus_arbiter dut (
    .data_clk        (data_clk),
    .reset           (reset),
    .cpu_write       (cpu_write),
    .cpu_read        (cpu_read),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_waitrequest (cpu_waitrequest),
    .cpu_rdvalid     (cpu_rdvalid),
    .dec_valid       (dec_valid),
    .dec_write       (dec_write),
    .dec_page        (dec_page),
    .dec_addr        (dec_addr),
    .dec_wdata       (dec_wdata),
    .dec_ready       (dec_ready),
    .dec_rdata       (dec_rdata),
    .bus_sel         (bus_sel),
    .bus_adr         (bus_adr),
    .bus_write       (bus_write),
    .bus_read        (bus_read),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .syx_out         (syx_out),
    .midi_ch         (midi_ch)
  );

  always #5 data_clk = ~data_clk;

  task automatic test_reset();
    reset = 1'b1;
    cpu_write = 0; cpu_read = 0; cpu_addr = '0; cpu_wdata = '0;
    dec_valid = 0; dec_write = 0; dec_page = '0; dec_addr = '0; dec_wdata = '0;
    bus_rdata = '0;
    repeat (3) @(negedge data_clk);
    reset = 1'b0;
    @(negedge data_clk);
    checks++;
    if (midi_ch !== 16'h3210) begin errors++; $display("FAIL reset_midi_ch: got %h want %h", midi_ch, 16'h3210); end
    checks++;
    if ({bus_write, bus_read} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {bus_write, bus_read}); end
    checks++;
    if (bus_sel !== 5'b0) begin errors++; $display("FAIL reset_bus_sel: got %b want 00000", bus_sel); end
    checks++;
    if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq: got %b want 0", cpu_waitrequest); end
    checks++;
    if ({cpu_rdvalid, dec_ready, syx_out} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {cpu_rdvalid, dec_ready, syx_out}); end
  endtask

  task automatic test_cpu_write();
    cpu_write = 1'b1;
    cpu_addr  = {3'd1, 7'h10};
    cpu_wdata = 32'h0000_005A;
    #1;
    checks++;
    if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_waitreq_c0: got %b want 1", cpu_waitrequest); end
    @(negedge data_clk);
    checks++;
    if (bus_sel !== 5'b00010) begin errors++; $display("FAIL wr_bus_sel: got %b want 00010", bus_sel); end
    checks++;
    if (bus_adr !== 7'h10) begin errors++; $display("FAIL wr_bus_adr: got %h want 10", bus_adr); end
    checks++;
    if ({bus_write, bus_read} !== 2'b10) begin errors++; $display("FAIL wr_strobe: got %b want 10", {bus_write, bus_read}); end
    checks++;
    if (bus_wdata !== 8'h5A) begin errors++; $display("FAIL wr_bus_wdata: got %h want 5a", bus_wdata); end
    checks++;
    if ({syx_out, cpu_waitrequest} !== 2'b01) begin errors++; $display("FAIL wr_c1_syx_wait: got %b want 01", {syx_out, cpu_waitrequest}); end
    @(negedge data_clk);
    checks++;
    if ({cpu_waitrequest, bus_write} !== 2'b00) begin errors++; $display("FAIL wr_c2_done: got %b want 00", {cpu_waitrequest, bus_write}); end
    cpu_write = 1'b0;
    @(negedge data_clk);
  endtask

  task automatic test_com_channel();
    int wr_cnt = 0;
    int wr_syx = 0;
    int got_c  = 0;
    dec_valid = 1'b1; dec_write = 1'b1; dec_page = 3'd4; dec_addr = 7'd4; dec_wdata = 8'h09;
    bus_rdata = 8'hA7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge data_clk);
      if (bus_write) begin wr_cnt++; if (syx_out) wr_syx++; end
      if (dec_ready) begin got_c = c; dec_valid = 1'b0; break; end
    end
    checks++;
    if (got_c !== 2) begin errors++; $display("FAIL com_dec_ready_cycle: got %0d want 2", got_c); end
    checks++;
    if ({wr_cnt, wr_syx} !== {32'd1, 32'd1}) begin errors++; $display("FAIL com_bus_write_syx: got %0d/%0d want 1/1", wr_cnt, wr_syx); end
    @(negedge data_clk);
    checks++;
    if (midi_ch !== 16'h3910) begin errors++; $display("FAIL com_midi_ch: got %h want 3910", midi_ch); end
    cpu_read = 1'b1;
    cpu_addr = {3'd4, 7'd4};
    got_c = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge data_clk);
      if (cpu_rdvalid) begin
        got_c = c;
        checks++;
        if (cpu_rdata !== 32'h9) begin errors++; $display("FAIL com_cpu_rdata: got %h want 9", cpu_rdata); end
        cpu_read = 1'b0;
        break;
      end
    end
    checks++;
    if (got_c !== 3) begin errors++; $display("FAIL com_rdvalid_cycle: got %0d want 3", got_c); end
    @(negedge data_clk);
  endtask

  task automatic test_contention();
    int n_strb = 0;
    int first_c = 0, sec_c = 0, dec_c = 0, cpu_c = 0;
    logic first_rd = 0, first_syx = 0, sec_wr = 0, sec_syx = 1;
    logic [DATA_W-1:0] dec_d = '0;
    logic [2:0] pat = 3'b000;
    bus_rdata = 8'hC5;
    cpu_write = 1'b1; cpu_addr = {3'd0, 7'd3}; cpu_wdata = 32'h33;
    dec_valid = 1'b1; dec_write = 1'b0; dec_page = 3'd0; dec_addr = 7'd3;
    for (int c = 1; c <= 20; c++) begin
      @(negedge data_clk);
      if (bus_read || bus_write) begin
        n_strb++;
        if (n_strb == 1) begin first_rd = bus_read; first_syx = syx_out; first_c = c; end
        else if (n_strb == 2) begin sec_wr = bus_write; sec_syx = syx_out; sec_c = c; end
      end
      if (dec_ready) begin dec_c = c; dec_d = dec_rdata; dec_valid = 1'b0; end
      if (cpu_write && !cpu_waitrequest) begin cpu_c = c; cpu_write = 1'b0; end
      if (cpu_c != 0 && dec_c != 0) break;
    end
    checks++;
    if ({first_rd, first_syx} !== 2'b11 || first_c != 1) begin errors++; $display("FAIL arb_first_dec: got rd=%b syx=%b c=%0d want 1 1 1", first_rd, first_syx, first_c); end
    checks++;
    if (dec_c != 3 || dec_d !== 8'hC5) begin errors++; $display("FAIL arb_dec_read: got c=%0d d=%h want 3 c5", dec_c, dec_d); end
    checks++;
    if ({sec_wr, sec_syx} !== 2'b10 || sec_c != 5) begin errors++; $display("FAIL arb_cpu_second: got wr=%b syx=%b c=%0d want 1 0 5", sec_wr, sec_syx, sec_c); end
    checks++;
    if (cpu_c != 6) begin errors++; $display("FAIL arb_cpu_done_cycle: got %0d want 6", cpu_c); end
    @(negedge data_clk);
    // Sustained contention: owner of the first three strobes.
    n_strb = 0;
    cpu_write = 1'b1;
    dec_valid = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge data_clk);
      if (bus_read || bus_write) begin
        pat[2 - n_strb] = syx_out;
        n_strb++;
        if (n_strb == 3) break;
      end
    end
    cpu_write = 1'b0;
    dec_valid = 1'b0;
    checks++;
    if (n_strb != 3 || pat !== EXP_PAT) begin errors++; $display("FAIL arb_pattern: got n=%0d pat=%b want 3 %b", n_strb, pat, EXP_PAT); end
    repeat (8) @(negedge data_clk);
  endtask

  task automatic test_invalid_page();
    int strb = 0;
    int got_c = 0;
    bus_rdata = 8'hFF;
    cpu_read = 1'b1;
    cpu_addr = {3'd6, 7'h11};
    for (int c = 1; c <= 10; c++) begin
      @(negedge data_clk);
      if (bus_read || bus_write || (bus_sel != 5'b0)) strb++;
      if (cpu_rdvalid) begin
        got_c = c;
        checks++;
        if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL inv_rdata: got %h want 0", cpu_rdata); end
        cpu_read = 1'b0;
        break;
      end
    end
    checks++;
    if (got_c !== 3) begin errors++; $display("FAIL inv_rdvalid_cycle: got %0d want 3", got_c); end
    checks++;
    if (strb !== 0) begin errors++; $display("FAIL inv_no_strobe: got %0d want 0", strb); end
    @(negedge data_clk);
  endtask

  task automatic test_reset_mid();
    int rdv = 0;
    int got_c = 0;
    bus_rdata = 8'h7E;
    cpu_read = 1'b1;
    cpu_addr = {3'd1, 7'd5};
    @(negedge data_clk);
    @(negedge data_clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (midi_ch !== 16'h3210) begin errors++; $display("FAIL rst_mid_midi_ch: got %h want 3210", midi_ch); end
    checks++;
    if ({syx_out, cpu_rdvalid, bus_read, bus_sel} !== 8'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b want 0", {syx_out, cpu_rdvalid, bus_read, bus_sel}); end
    cpu_read = 1'b0;
    @(negedge data_clk);
    @(negedge data_clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge data_clk);
      if (cpu_rdvalid || bus_read) rdv++;
    end
    checks++;
    if (rdv !== 0) begin errors++; $display("FAIL rst_mid_no_completion: got %0d want 0", rdv); end
    cpu_read = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge data_clk);
      if (cpu_rdvalid) begin
        got_c = c;
        checks++;
        if (cpu_rdata !== 32'h7E) begin errors++; $display("FAIL rst_mid_next_rdata: got %h want 7e", cpu_rdata); end
        cpu_read = 1'b0;
        break;
      end
    end
    checks++;
    if (got_c !== 3) begin errors++; $display("FAIL rst_mid_next_cycle: got %0d want 3", got_c); end
    @(negedge data_clk);
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_com_channel();
    test_contention();
    test_invalid_page();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
